// File: rtl/visibility_accumulator_axis_if.sv
// Output stream bundle for visibility_accumulator_axis.
// The accumulator drives the master side; the readout/DMA block is the slave.
interface visibility_accumulator_axis_if #(
  parameter int WIDTH = 36
) ();

  logic                    m_tvalid;
  logic                    m_tready;
  logic                    m_tlast;
  logic signed [WIDTH-1:0] m_revis;
  logic signed [WIDTH-1:0] m_imvis;

  modport master (
    output m_tvalid,
    output m_tlast,
    output m_revis,
    output m_imvis,
    input  m_tready
  );

  modport slave (
    input  m_tvalid,
    input  m_tlast,
    input  m_revis,
    input  m_imvis,
    output m_tready
  );

endinterface

// File: rtl/visibility_accumulator_axis.sv
// Read-modify-write visibility accumulator.
// Correlator partial sums (re/im) are accumulated per baseline pair in a
// PAIRS-deep SRAM over count_i passes.  During the final pass each finished
// visibility is pushed into an output FIFO that feeds a backpressured stream.
// Three-stage pipeline per accepted input: sample+read, add, write+push.
// Optional build macro SATURATE_EN: adders clip instead of wrapping and a
// sticky sat_o output is added.
module visibility_accumulator_axis #(
  parameter int CORES  = 18,
  parameter int TRATE  = 30,
  parameter int WIDTH  = 36,
  parameter int SBITS  = 7,
  parameter int CBITS  = 16,
  parameter int FDEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [CBITS-1:0]         count_i,
  input  logic                     valid_i,
  input  logic                     last_i,
  input  logic signed [SBITS-1:0]  revis_i,
  input  logic signed [SBITS-1:0]  imvis_i,
  visibility_accumulator_axis_if.master m_axis,
  output logic                     overflow_o,
  output logic                     desync_o
`ifdef SATURATE_EN
  ,
  output logic                     sat_o
`endif
);

  localparam int PAIRS = CORES * TRATE;
  localparam int AW    = $clog2(PAIRS);
  localparam int FW    = $clog2(FDEPTH);
  localparam int LW    = $clog2(FDEPTH + 1);

  localparam logic [AW-1:0] LAST_ADDR = AW'(PAIRS - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FDEPTH);

`ifdef SATURATE_EN
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  // ---------------------------------------------------------------- storage
  logic signed [WIDTH-1:0] acc_mem_re [PAIRS];
  logic signed [WIDTH-1:0] acc_mem_im [PAIRS];

  logic signed [WIDTH-1:0] fifo_re   [FDEPTH];
  logic signed [WIDTH-1:0] fifo_im   [FDEPTH];
  logic                    fifo_last [FDEPTH];

  // ---------------------------------------------------------------- S0 state
  logic [AW-1:0]    addr;
  logic [CBITS-1:0] pass;
  logic [CBITS-1:0] cnt_lat;

  logic [CBITS-1:0] cnt_eff;
  logic [CBITS-1:0] cnt_cur;
  logic             at_start;
  logic             at_end;
  logic             is_final;
  logic             pass_end;

  // ---------------------------------------------------------------- S1 regs
  logic                    s1_valid;
  logic [AW-1:0]           s1_addr;
  logic signed [WIDTH-1:0] s1_re;
  logic signed [WIDTH-1:0] s1_im;
  logic                    s1_first;
  logic                    s1_final;
  logic                    s1_tlast;
  logic signed [WIDTH-1:0] rd_re;
  logic signed [WIDTH-1:0] rd_im;

  logic signed [WIDTH-1:0] base_re;
  logic signed [WIDTH-1:0] base_im;
  logic signed [WIDTH-1:0] acc_re;
  logic signed [WIDTH-1:0] acc_im;
`ifdef SATURATE_EN
  logic signed [WIDTH:0]   wide_re;
  logic signed [WIDTH:0]   wide_im;
  logic                    clip_re;
  logic                    clip_im;
`endif

  // ---------------------------------------------------------------- S2 regs
  logic                    s2_valid;
  logic [AW-1:0]           s2_addr;
  logic signed [WIDTH-1:0] s2_acc_re;
  logic signed [WIDTH-1:0] s2_acc_im;
  logic                    s2_final;
  logic                    s2_tlast;

  // ---------------------------------------------------------------- FIFO
  logic [FW-1:0]           wr_ptr;
  logic [FW-1:0]           rd_ptr;
  logic [LW-1:0]           level;
  logic                    out_valid;
  logic                    out_last;
  logic signed [WIDTH-1:0] out_re;
  logic signed [WIDTH-1:0] out_im;

  logic push_req;
  logic push_ok;
  logic pop_out;
  logic load_out;
  logic mem_empty;

  // Pass bookkeeping for the pair presented this cycle; count_i==0 acts as 1
  // and is only honoured on the first pair of a dump.
  always_comb begin
    cnt_eff  = (count_i == '0) ? CBITS'(1) : count_i;
    at_start = (pass == '0) && (addr == '0);
    cnt_cur  = at_start ? cnt_eff : cnt_lat;
    is_final = (pass == cnt_cur - CBITS'(1));
    at_end   = (addr == LAST_ADDR);
    pass_end = at_end || last_i;
  end

  // Address/pass counters; an early last_i flags desync and restarts at 0.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr     <= '0;
      pass     <= '0;
      cnt_lat  <= '0;
      desync_o <= 1'b0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= valid_i;
      if (valid_i) begin
        if (at_start) cnt_lat <= cnt_eff;
        if (last_i && !at_end) desync_o <= 1'b1;
        if (pass_end) begin
          addr <= '0;
          pass <= is_final ? '0 : pass + CBITS'(1);
        end else begin
          addr <= addr + AW'(1);
        end
      end
    end
  end

  // S0 capture and SRAM read; a resync can revisit an address still in flight,
  // so the newest in-pipeline sum is forwarded ahead of the array contents.
  always_ff @(posedge clock) begin
    if (valid_i) begin
      s1_addr  <= addr;
      s1_re    <= {{(WIDTH-SBITS){revis_i[SBITS-1]}}, revis_i};
      s1_im    <= {{(WIDTH-SBITS){imvis_i[SBITS-1]}}, imvis_i};
      s1_first <= (pass == '0);
      s1_final <= is_final;
      s1_tlast <= is_final && at_end;
      if (s1_valid && (s1_addr == addr)) begin
        rd_re <= acc_re;
        rd_im <= acc_im;
      end else if (s2_valid && (s2_addr == addr)) begin
        rd_re <= s2_acc_re;
        rd_im <= s2_acc_im;
      end else begin
        rd_re <= acc_mem_re[addr];
        rd_im <= acc_mem_im[addr];
      end
    end
  end

  // S1 adder: the first pass of a dump ignores whatever the SRAM holds.
  always_comb begin
    base_re = s1_first ? '0 : rd_re;
    base_im = s1_first ? '0 : rd_im;
`ifdef SATURATE_EN
    wide_re = {base_re[WIDTH-1], base_re} + {s1_re[WIDTH-1], s1_re};
    wide_im = {base_im[WIDTH-1], base_im} + {s1_im[WIDTH-1], s1_im};
    clip_re = (wide_re[WIDTH] != wide_re[WIDTH-1]);
    clip_im = (wide_im[WIDTH] != wide_im[WIDTH-1]);
    acc_re  = clip_re ? (wide_re[WIDTH] ? SMIN : SMAX) : wide_re[WIDTH-1:0];
    acc_im  = clip_im ? (wide_im[WIDTH] ? SMIN : SMAX) : wide_im[WIDTH-1:0];
`else
    acc_re  = base_re + s1_re;
    acc_im  = base_im + s1_im;
`endif
  end

`ifdef SATURATE_EN
  // Sticky clip indicator.
  always_ff @(posedge clock) begin
    if (!reset_n) sat_o <= 1'b0;
    else if (s1_valid && (clip_re || clip_im)) sat_o <= 1'b1;
  end
`endif

  // S2 valid flag; cleared on reset so in-flight work is discarded.
  always_ff @(posedge clock) begin
    if (!reset_n) s2_valid <= 1'b0;
    else          s2_valid <= s1_valid;
  end

  // S2 data registers.
  always_ff @(posedge clock) begin
    if (s1_valid) begin
      s2_addr   <= s1_addr;
      s2_acc_re <= acc_re;
      s2_acc_im <= acc_im;
      s2_final  <= s1_final;
      s2_tlast  <= s1_tlast;
    end
  end

  // S2 write-back into the accumulator SRAM.
  always_ff @(posedge clock) begin
    if (s2_valid) begin
      acc_mem_re[s2_addr] <= s2_acc_re;
      acc_mem_im[s2_addr] <= s2_acc_im;
    end
  end

  // FIFO handshake terms; level counts queued words plus the output register.
  always_comb begin
    push_req  = s2_valid && s2_final;
    pop_out   = out_valid && m_axis.m_tready;
    load_out  = !out_valid || m_axis.m_tready;
    mem_empty = (wr_ptr == rd_ptr);
    push_ok   = push_req && ((level != FULL_LVL) || pop_out);
  end

  // FIFO storage write.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_re[wr_ptr]   <= s2_acc_re;
      fifo_im[wr_ptr]   <= s2_acc_im;
      fifo_last[wr_ptr] <= s2_tlast;
    end
  end

  // FIFO pointers, registered stream output and sticky overflow.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FW'(1);
      if (push_req && !push_ok) overflow_o <= 1'b1;
      level <= level + LW'(push_ok) - LW'(pop_out);
      if (load_out) begin
        if (!mem_empty) begin
          out_valid <= 1'b1;
          out_re    <= fifo_re[rd_ptr];
          out_im    <= fifo_im[rd_ptr];
          out_last  <= fifo_last[rd_ptr];
          rd_ptr    <= rd_ptr + FW'(1);
        end else begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end
    end
  end

  assign m_axis.m_tvalid = out_valid;
  assign m_axis.m_tlast  = out_last;
  assign m_axis.m_revis  = out_re;
  assign m_axis.m_imvis  = out_im;

endmodule

// File: tb/tb_visibility_accumulator_axis.sv
// Self-checking bench for visibility_accumulator_axis (small configuration).
// Build with SATURATE_EN defined to exercise the clipping variant.
module tb_visibility_accumulator_axis;

  localparam int CORES  = 2;
  localparam int TRATE  = 2;
  localparam int PAIRS  = CORES * TRATE;
  localparam int WIDTH  = 12;
  localparam int SBITS  = 4;
  localparam int CBITS  = 16;
  localparam int FDEPTH = 4;
  localparam int VMAX   = 2 ** (WIDTH - 1) - 1;
  localparam int VMIN   = -(2 ** (WIDTH - 1));

  typedef struct {
    int re;
    int im;
    bit last;
  } word_t;

  logic                    clock = 1'b0;
  logic                    reset_n = 1'b0;
  logic [CBITS-1:0]        count_i = '0;
  logic                    valid_i = 1'b0;
  logic                    last_i = 1'b0;
  logic signed [SBITS-1:0] revis_i = '0;
  logic signed [SBITS-1:0] imvis_i = '0;
  logic                    overflow_o;
  logic                    desync_o;
`ifdef SATURATE_EN
  logic                    sat_o;
`endif

  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;
  int first_valid_edge = -1;

  word_t got_q[$];
  word_t exp_q[$];

  // reference model state: per-pair running sums and dump position
  int mdl_addr = 0;
  int mdl_pass = 0;
  int mdl_cnt  = 1;
  int mdl_re [PAIRS];
  int mdl_im [PAIRS];
  bit mdl_sat = 0;

  visibility_accumulator_axis_if #(.WIDTH(WIDTH)) axis ();

  visibility_accumulator_axis #(
    .CORES(CORES), .TRATE(TRATE), .WIDTH(WIDTH),
    .SBITS(SBITS), .CBITS(CBITS), .FDEPTH(FDEPTH)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .count_i(count_i),
    .valid_i(valid_i),
    .last_i(last_i),
    .revis_i(revis_i),
    .imvis_i(imvis_i),
    .m_axis(axis),
    .overflow_o(overflow_o),
    .desync_o(desync_o)
`ifdef SATURATE_EN
    ,
    .sat_o(sat_o)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) edge_cnt = edge_cnt + 1;

  // record every transferred word (and first-valid time) half a cycle early
  always @(negedge clock) begin
    word_t w;
    if (axis.m_tvalid === 1'b1 && first_valid_edge < 0) first_valid_edge = edge_cnt;
    if (axis.m_tvalid === 1'b1 && axis.m_tready === 1'b1) begin
      w.re = int'(axis.m_revis);
      w.im = int'(axis.m_imvis);
      w.last = axis.m_tlast;
      got_q.push_back(w);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int fit(int x);
`ifdef SATURATE_EN
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
`else
    int y;
    y = ((x % (2 ** WIDTH)) + (2 ** WIDTH)) % (2 ** WIDTH);
    if (y > VMAX) y = y - (2 ** WIDTH);
    return y;
`endif
  endfunction

  function automatic int rnd_partial();
    return int'($urandom_range(0, 15)) - 8;
  endfunction

  task automatic model_accept(input int re, input int im, input bit last);
    bit first;
    bit fin;
    word_t w;
    if (mdl_pass == 0 && mdl_addr == 0) mdl_cnt = (count_i == 0) ? 1 : int'(count_i);
    first = (mdl_pass == 0);
    fin   = (mdl_pass == mdl_cnt - 1);
    if (first) begin
      mdl_re[mdl_addr] = re;
      mdl_im[mdl_addr] = im;
    end else begin
      if (mdl_re[mdl_addr] + re > VMAX || mdl_re[mdl_addr] + re < VMIN) mdl_sat = 1;
      if (mdl_im[mdl_addr] + im > VMAX || mdl_im[mdl_addr] + im < VMIN) mdl_sat = 1;
      mdl_re[mdl_addr] = fit(mdl_re[mdl_addr] + re);
      mdl_im[mdl_addr] = fit(mdl_im[mdl_addr] + im);
    end
    if (fin) begin
      w.re = mdl_re[mdl_addr];
      w.im = mdl_im[mdl_addr];
      w.last = (mdl_addr == PAIRS - 1);
      exp_q.push_back(w);
    end
    if (mdl_addr == PAIRS - 1 || last) begin
      mdl_addr = 0;
      mdl_pass = fin ? 0 : mdl_pass + 1;
    end else begin
      mdl_addr = mdl_addr + 1;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int re, input int im, input bit last);
    valid_i = 1'b1;
    last_i  = last;
    revis_i = SBITS'(re);
    imvis_i = SBITS'(im);
    model_accept(re, im, last);
    tick();
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, output bit timed_out);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    timed_out = (got_q.size() < n);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    axis.m_tready = 1'b1;
    count_i = 1;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    mdl_addr = 0;
    mdl_pass = 0;
    got_q.delete();
    exp_q.delete();
    vectors++;
    if (axis.m_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_tvalid: got %b expected 0", axis.m_tvalid);
    end
    vectors++;
    if (axis.m_tlast !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_tlast: got %b expected 0", axis.m_tlast);
    end
    vectors++;
    if (overflow_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_overflow: got %b expected 0", overflow_o);
    end
    vectors++;
    if (desync_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_desync: got %b expected 0", desync_o);
    end
`ifdef SATURATE_EN
    vectors++;
    if (sat_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_sat: got %b expected 0", sat_o);
    end
`endif
  endtask

  task automatic test_basic();
    int accept_edge;
    bit to;
    count_i = 1;
    first_valid_edge = -1;
    accept_edge = -1;
    for (int i = 0; i < PAIRS; i++) begin
      applyStimulus(i + 1, -(i + 1), i == PAIRS - 1);
      if (i == 0) accept_edge = edge_cnt;
    end
    wait_words(PAIRS, 30, to);
    vectors++;
    if (first_valid_edge - accept_edge !== 3) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: got %0d cycles expected 3", first_valid_edge - accept_edge);
    end
    vectors++;
    if (to) begin
      miscompares++;
      $display("[TB] FAIL basic_timeout: got %0d words expected %0d", got_q.size(), PAIRS);
    end else begin
      for (int i = 0; i < PAIRS; i++) begin
        word_t g, e;
        g = got_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (g.re !== e.re || g.im !== e.im || g.last !== e.last) begin
          miscompares++;
          $display("[TB] FAIL basic_word%0d: got re=%0d im=%0d last=%0d expected re=%0d im=%0d last=%0d",
                   i, g.re, g.im, g.last, e.re, e.im, e.last);
        end
      end
    end
  endtask

  task automatic test_multi_pass();
    bit to;
    count_i = 3;
    for (int p = 0; p < 3; p++) begin
      for (int a = 0; a < PAIRS; a++) begin
        applyStimulus(7, -8, a == PAIRS - 1);
        repeat ($urandom_range(0, 2)) tick();
      end
      if (p == 1) begin
        repeat (6) tick();
        vectors++;
        if (got_q.size() !== 0) begin
          miscompares++;
          $display("[TB] FAIL multi_early_output: got %0d words expected 0", got_q.size());
        end
      end
    end
    wait_words(PAIRS, 30, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("[TB] FAIL multi_timeout: got %0d words expected %0d", got_q.size(), PAIRS);
    end else begin
      for (int i = 0; i < PAIRS; i++) begin
        word_t g, e;
        g = got_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (g.re !== e.re || g.im !== e.im || g.last !== e.last) begin
          miscompares++;
          $display("[TB] FAIL multi_word%0d: got re=%0d im=%0d last=%0d expected re=%0d im=%0d last=%0d",
                   i, g.re, g.im, g.last, e.re, e.im, e.last);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    count_i = 2;
    for (int p = 0; p < 4; p++)
      for (int a = 0; a < PAIRS; a++)
        applyStimulus(rnd_partial(), rnd_partial(), a == PAIRS - 1);
    wait_words(2 * PAIRS, 30, to);
    repeat (4) tick();
    vectors++;
    if (to || got_q.size() != 2 * PAIRS) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d words expected %0d", got_q.size(), 2 * PAIRS);
      got_q.delete();
      exp_q.delete();
    end else begin
      for (int i = 0; i < 2 * PAIRS; i++) begin
        word_t g, e;
        g = got_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (g.re !== e.re || g.im !== e.im || g.last !== e.last) begin
          miscompares++;
          $display("[TB] FAIL b2b_word%0d: got re=%0d im=%0d last=%0d expected re=%0d im=%0d last=%0d",
                   i, g.re, g.im, g.last, e.re, e.im, e.last);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int n0;
    count_i = 1;
    axis.m_tready = 1'b0;
    for (int a = 0; a < PAIRS; a++) applyStimulus(rnd_partial(), rnd_partial(), a == PAIRS - 1);
    for (int c = 0; c < 8; c++) begin
      tick();
      vectors++;
      if (axis.m_tvalid !== 1'b1 || int'(axis.m_revis) !== exp_q[0].re ||
          int'(axis.m_imvis) !== exp_q[0].im || axis.m_tlast !== exp_q[0].last) begin
        miscompares++;
        $display("[TB] FAIL stall_hold%0d: got v=%b re=%0d im=%0d expected v=1 re=%0d im=%0d",
                 c, axis.m_tvalid, int'(axis.m_revis), int'(axis.m_imvis), exp_q[0].re, exp_q[0].im);
      end
    end
    axis.m_tready = 1'b1;
    wait_words(PAIRS, 30, to);
    repeat (4) tick();
    vectors++;
    if (overflow_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_overflow: got %b expected 0", overflow_o);
    end
    vectors++;
    if (to || got_q.size() != PAIRS) begin
      miscompares++;
      $display("[TB] FAIL stall_count: got %0d words expected %0d", got_q.size(), PAIRS);
      got_q.delete();
      exp_q.delete();
    end else begin
      for (int i = 0; i < PAIRS; i++) begin
        word_t g, e;
        g = got_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (g.re !== e.re || g.im !== e.im || g.last !== e.last) begin
          miscompares++;
          $display("[TB] FAIL stall_word%0d: got re=%0d im=%0d last=%0d expected re=%0d im=%0d last=%0d",
                   i, g.re, g.im, g.last, e.re, e.im, e.last);
        end
      end
    end

    // second dump while still stalled: the full FIFO drops every new word
    axis.m_tready = 1'b0;
    for (int a = 0; a < PAIRS; a++) applyStimulus(rnd_partial(), rnd_partial(), a == PAIRS - 1);
    repeat (4) tick();
    n0 = exp_q.size();
    for (int a = 0; a < PAIRS; a++) applyStimulus(rnd_partial(), rnd_partial(), a == PAIRS - 1);
    while (exp_q.size() > n0) void'(exp_q.pop_back());
    repeat (4) tick();
    vectors++;
    if (overflow_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL full_overflow: got %b expected 1", overflow_o);
    end
    axis.m_tready = 1'b1;
    wait_words(PAIRS, 30, to);
    repeat (8) tick();
    vectors++;
    if (got_q.size() != PAIRS) begin
      miscompares++;
      $display("[TB] FAIL full_count: got %0d words expected %0d", got_q.size(), PAIRS);
      got_q.delete();
      exp_q.delete();
    end else begin
      for (int i = 0; i < PAIRS; i++) begin
        word_t g, e;
        g = got_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (g.re !== e.re || g.im !== e.im || g.last !== e.last) begin
          miscompares++;
          $display("[TB] FAIL full_word%0d: got re=%0d im=%0d last=%0d expected re=%0d im=%0d last=%0d",
                   i, g.re, g.im, g.last, e.re, e.im, e.last);
        end
      end
    end

    // a later dump is unaffected by the drop
    for (int a = 0; a < PAIRS; a++) applyStimulus(rnd_partial(), rnd_partial(), a == PAIRS - 1);
    wait_words(PAIRS, 30, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("[TB] FAIL after_full_timeout: got %0d words expected %0d", got_q.size(), PAIRS);
    end else begin
      for (int i = 0; i < PAIRS; i++) begin
        word_t g, e;
        g = got_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (g.re !== e.re || g.im !== e.im || g.last !== e.last) begin
          miscompares++;
          $display("[TB] FAIL after_full_word%0d: got re=%0d im=%0d last=%0d expected re=%0d im=%0d last=%0d",
                   i, g.re, g.im, g.last, e.re, e.im, e.last);
        end
      end
    end
  endtask

  task automatic test_desync();
    bit to;
    count_i = 2;
    applyStimulus(rnd_partial(), rnd_partial(), 1'b0);
    applyStimulus(rnd_partial(), rnd_partial(), 1'b1);
    vectors++;
    if (desync_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL desync_flag: got %b expected 1", desync_o);
    end
    for (int a = 0; a < PAIRS; a++) applyStimulus(rnd_partial(), rnd_partial(), a == PAIRS - 1);
    wait_words(PAIRS, 30, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("[TB] FAIL desync_timeout: got %0d words expected %0d", got_q.size(), PAIRS);
    end else begin
      for (int i = 0; i < PAIRS; i++) begin
        word_t g, e;
        g = got_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (g.re !== e.re || g.im !== e.im || g.last !== e.last) begin
          miscompares++;
          $display("[TB] FAIL desync_word%0d: got re=%0d im=%0d last=%0d expected re=%0d im=%0d last=%0d",
                   i, g.re, g.im, g.last, e.re, e.im, e.last);
        end
      end
    end
  endtask

  task automatic test_wrap();
    bit to;
    int want_re;
`ifdef SATURATE_EN
    want_re = VMAX;
`else
    want_re = 2100 - 4096;
`endif
    count_i = 300;
    for (int p = 0; p < 300; p++)
      for (int a = 0; a < PAIRS; a++)
        applyStimulus(7, rnd_partial(), a == PAIRS - 1);
    wait_words(PAIRS, 30, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("[TB] FAIL wrap_timeout: got %0d words expected %0d", got_q.size(), PAIRS);
    end else begin
      for (int i = 0; i < PAIRS; i++) begin
        word_t g, e;
        g = got_q.pop_front();
        e = exp_q.pop_front();
        vectors++;
        if (g.re !== want_re || g.re !== e.re || g.im !== e.im || g.last !== e.last) begin
          miscompares++;
          $display("[TB] FAIL wrap_word%0d: got re=%0d im=%0d last=%0d expected re=%0d im=%0d last=%0d",
                   i, g.re, g.im, g.last, want_re, e.im, e.last);
        end
      end
    end
`ifdef SATURATE_EN
    vectors++;
    if (sat_o !== 1'b1 || mdl_sat !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wrap_sat: got %b expected 1", sat_o);
    end
`endif
  endtask

  initial begin
    axis.m_tready = 1'b1;
    test_reset();
    test_basic();
    test_multi_pass();
    test_back_to_back();
    test_backpressure();
    test_desync();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
